// File: rtl/control_fsm_pkg.sv
// Shared control-path definitions: FSM state encoding, ALU op codes and instruction fields.
// Also used by the ALU and datapath blocks.
package control_fsm_pkg;

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_IFETCH = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] opcode, input logic [5:0] func);
    instr_class_e cls;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR: cls = CLS_RTYPE;
          default:                       cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LOAD;
      OP_SW:   cls = CLS_STORE;
      OP_BEQ:  cls = CLS_BRANCH;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_fsm_alu_decode.sv
// Combinational instruction decode: opcode/func -> ALU operation, B-operand select, legality.
module alu_decode
  import control_fsm_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output logic [3:0] alu_op_o,
  output logic       alu_bsel_o,
  output logic       legal_o
);

  instr_class_e cls_s;

  assign cls_s = classify(opcode_i, func_i);

  always_comb begin
    alu_op_o   = ALU_PASS_A;
    alu_bsel_o = 1'b0;
    legal_o    = (cls_s != CLS_ILLEGAL);
    case (cls_s)
      CLS_RTYPE: begin
        case (func_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          default: alu_op_o = ALU_PASS_A;
        endcase
      end
      // Loads, stores and ADDI all add the sign-extended immediate.
      CLS_ADDI, CLS_LOAD, CLS_STORE: begin
        alu_op_o   = ALU_ADD;
        alu_bsel_o = 1'b1;
      end
      CLS_BRANCH: alu_op_o = ALU_SUB;
      default:    alu_op_o = ALU_PASS_A;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM for a small MIPS subset: sequences fetch, decode, execute,
// memory and write-back, and drives the datapath control strobes.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_src_o,
  output logic [3:0] alu_op_o,
  output logic       alu_bsel_o,
  output logic       rf_we_o,
  output logic       rf_wsel_o,
  output logic       rf_dst_o,
  output logic       illegal_o
);

  logic [2:0]   state_q, state_d;
  logic [5:0]   opcode_q, func_q;
  logic [5:0]   dec_opcode_s, dec_func_s;
  logic [3:0]   dec_alu_op_s;
  logic         dec_bsel_s, dec_legal_s;
  instr_class_e cls_q_s;

  // DECODE judges the live instruction bits; every later state works from the latched copy.
  assign dec_opcode_s = (state_q == ST_DECODE) ? opcode_i : opcode_q;
  assign dec_func_s   = (state_q == ST_DECODE) ? func_i   : func_q;
  assign cls_q_s      = classify(opcode_q, func_q);

  alu_decode u_alu_decode (
    .opcode_i   (dec_opcode_s),
    .func_i     (dec_func_s),
    .alu_op_o   (dec_alu_op_s),
    .alu_bsel_o (dec_bsel_s),
    .legal_o    (dec_legal_s)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_START;
      opcode_q <= 6'd0;
      func_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode_i;
        func_q   <= func_i;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_src_o       = 1'b0;
    alu_op_o       = ALU_PASS_A;
    alu_bsel_o     = 1'b0;
    rf_we_o        = 1'b0;
    rf_wsel_o      = 1'b0;
    rf_dst_o       = 1'b0;
    illegal_o      = 1'b0;
    case (state_q)
      ST_START: state_d = ST_IFETCH;
      ST_IFETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IFETCH;
        end
      end
      ST_DECODE: begin
        if (dec_legal_s) begin
          state_d = ST_EXEC;
        end else begin
          illegal_o = 1'b1;
          state_d   = ST_IFETCH;
        end
      end
      ST_EXEC: begin
        alu_op_o   = dec_alu_op_s;
        alu_bsel_o = dec_bsel_s;
        if (cls_q_s == CLS_BRANCH) begin
          pc_we_o  = zero_i;
          pc_src_o = 1'b1;
          state_d  = ST_IFETCH;
        end else if ((cls_q_s == CLS_LOAD) || (cls_q_s == CLS_STORE)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (cls_q_s == CLS_STORE);
        if (mem_ack_i) begin
          state_d = (cls_q_s == CLS_STORE) ? ST_IFETCH : ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_o   = 1'b1;
        rf_wsel_o = (cls_q_s == CLS_LOAD);
        rf_dst_o  = (cls_q_s == CLS_RTYPE);
        state_d   = ST_IFETCH;
      end
      default: state_d = ST_START;
    endcase
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Clk  in  1  sole clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Opcode  in  6  instruction bits [31:26], sampled only in DECODE.
REQ-004 Func  in  6  instruction bits [5:0], sampled only in DECODE.
REQ-005 Zero  in  1  ALU zero flag, sampled only in EXEC of BEQ.
REQ-006 Mem_ack  in  1  memory completion; valid only while Mem_req=1.
REQ-007 Mem_req  out  1  memory request; held high until Mem_ack.
REQ-008 Mem_we  out  1  store qualifier; valid with Mem_req.
REQ-009 Mem_addr_sel  out  1  0=PC, 1=ALU result register.
REQ-010 IR_we  out  1  instruction register load.
REQ-011 PC_we  out  1  PC load.
REQ-012 PC_src  out  1  0=PC+4, 1=branch target.
REQ-013 ALU_op  out  4  ALU opcode to datapath ALU.
REQ-014 ALU_bsel  out  1  0=register B, 1=sign-extended immediate.
REQ-015 RF_we  out  1  register-file write.
REQ-016 RF_wsel  out  1  write data: 0=ALU result, 1=memory data.
REQ-017 RF_dst  out  1  destination: 0=rt, 1=rd.
REQ-018 Illegal  out  1  one-cycle pulse on unsupported opcode/func.

Function
REQ-019 ALU_op encodings SHALL be 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 1111 PASS_A.
REQ-020 Supported: R-type (000000) func 100000 ADD, 100010 SUB, 100100 AND, 100101 OR; ADDI 001000; LW 100011; SW 101011; BEQ 000100.
REQ-021 States SHALL be START, IFETCH, DECODE, EXEC, MEM, WB.
REQ-022 START: all outputs 0, ALU_op=1111; next IFETCH unconditionally.
REQ-023 IFETCH: Mem_req=1, Mem_addr_sel=0, Mem_we=0; while Mem_ack=0 remain; on Mem_ack=1 assert IR_we=1, PC_we=1, PC_src=0 in that same cycle and go to DECODE.
REQ-024 DECODE: latch Opcode/Func into internal registers; unsupported -> Illegal=1 for this cycle, next IFETCH; else next EXEC.
REQ-025 EXEC: ALU_op from latched fields (LW/SW/ADDI -> ADD, BEQ -> SUB, R-type per func); ALU_bsel=1 for LW/SW/ADDI, else 0.
REQ-026 EXEC transitions: R-type/ADDI -> WB; LW/SW -> MEM; BEQ -> IFETCH, with PC_we=Zero, PC_src=1 that cycle.
REQ-027 MEM: Mem_req=1, Mem_addr_sel=1, Mem_we=1 for SW; hold until Mem_ack; on ack SW -> IFETCH, LW -> WB.
REQ-028 WB: RF_we=1 for one cycle; RF_wsel=1 for LW; RF_dst=1 for R-type only; next IFETCH.
REQ-029 All outputs except Illegal SHALL be Moore functions of state plus latched fields; Mem_ack/Zero influence only PC_we/IR_we and transitions as stated.
REQ-030 Mem_req SHALL never drop between assertion and Mem_ack; Mem_ack while Mem_req=0 SHALL be ignored.
REQ-031 Minimum latencies: R-type/ADDI 4 cycles, SW 4, LW 5, BEQ 3, illegal 2 (with 1-cycle Mem_ack).

Reset
REQ-032 Reset=1 SHALL force state START on the next edge from any state, including mid-handshake; pending Mem_ack is discarded.
REQ-033 Latched opcode/func SHALL reset to 0; Illegal SHALL be 0 in the cycle after Reset.

Structure
REQ-034 Shared package SHALL hold state encoding, ALU_op constants, opcode and func constants for reuse by alu and datapath.
REQ-035 One sub-module alu_decode (combinational: latched opcode/func -> ALU_op, ALU_bsel, legality) is natural; FSM stays in control_fsm.

Verification
REQ-036 Reset 2 cycles, Mem_ack=1 always -> START then IFETCH with Mem_req=1, PC_we=1, IR_we=1.
REQ-037 Opcode 000000/Func 100010, ack immediate -> EXEC ALU_op=0001, WB RF_we=1 RF_dst=1, total 4 cycles.
REQ-038 LW 100011, Mem_ack delayed 3 cycles in MEM -> Mem_req held 4 cycles with Mem_addr_sel=1, WB RF_wsel=1.
REQ-039 BEQ with Zero=1 -> EXEC PC_we=1 PC_src=1; Zero=0 -> PC_we=0; both return to IFETCH.
REQ-040 Opcode 111111 -> Illegal pulse one cycle in DECODE, RF_we/Mem_req never asserted, back to IFETCH.
REQ-041 Reset asserted in MEM of SW with Mem_ack pending -> START next edge, Mem_we=0, no PC_we.
